// File: rtl/imem_loader.sv
// Byte-serial loader for the 32-entry instruction memory: count byte, little-endian
// payload words, XOR checksum; fetch is enabled only after a frame verifies.
module imem_loader #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              inst_en,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [7:0]        acc_q, acc_d;
    logic [31:0]       word_q, word_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]       wr_data_q, wr_data_d;
    logic              in_ready_q, in_ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              inst_en_q, inst_en_d;
    logic              xfer_s;
    logic              last_word_s;
    logic              count_bad_s;

    assign xfer_s      = in_valid && in_ready_q;
    assign last_word_s = ({1'b0, word_idx_q} == (n_q - {{ADDR_W{1'b0}}, 1'b1}));
    assign count_bad_s = (in_data == 8'd0) || (int'(in_data) > DEPTH);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        acc_d      = acc_q;
        word_d     = word_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        // start overrides any byte arriving in the same cycle.
        if (start) begin
            state_d = S_COUNT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_COUNT: begin
                    if (xfer_s && count_bad_s) begin
                        state_d = S_ERR;
                    end else if (xfer_s) begin
                        n_d        = in_data[ADDR_W:0];
                        word_idx_d = {ADDR_W{1'b0}};
                        byte_idx_d = 2'd0;
                        acc_d      = 8'd0;
                        state_d    = S_DATA;
                    end else begin
                        state_d = S_COUNT;
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
                        word_d[{byte_idx_q, 3'b000} +: 8] = in_data;
                        acc_d      = acc_q ^ in_data;
                        byte_idx_d = byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = word_idx_q;
                            wr_data_d = {in_data, word_q[23:0]};
                            if (last_word_s) begin
                                state_d = S_CHECK;
                            end else begin
                                word_idx_d = word_idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                            end
                        end else begin
                            wr_en_d = 1'b0;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_CHECK: begin
                    if (xfer_s) begin
                        state_d = (in_data == acc_q) ? S_DONE : S_ERR;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
                S_DONE:  state_d = S_DONE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end

        // Status flags are decoded from the next state so they are registered.
        in_ready_d = (state_d == S_COUNT) || (state_d == S_DATA) || (state_d == S_CHECK);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        inst_en_d  = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            word_idx_q <= '0;
            byte_idx_q <= 2'd0;
            acc_q      <= 8'd0;
            word_q     <= 32'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 32'd0;
            in_ready_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            inst_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            acc_q      <= acc_d;
            word_q     <= word_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            in_ready_q <= in_ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            inst_en_q  <= inst_en_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign done     = done_q;
    assign err      = err_q;
    assign inst_en  = inst_en_q;

endmodule
